clk_sel_ctrl: RTL and testbench

Parametrised, handshaked clock-source select sequencer for N clock channels, each gated by an external clock gate or buffer (IBUFDS/IBUF-class source feeding a BUFGCE-style gate). It replaces the bare combinational `sel ? a : b` clock mux with a break-before-make sequence:
- Disable the current source.
- Confirm it is off via the gate's status acknowledge.
- Enable the new source.
- Confirm it is on.

A timeout catches dead sources. It runs entirely in the always-on system clock domain and sits between the config/CSR logic and the clock gates.

---
 rtl/clk_sel_ctrl.sv | 157 +++++++++++++++
 tb/tb_clk_sel_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_sel_ctrl.sv
// clk_sel_ctrl: break-before-make clock-source select sequencer.
// Disables the old gate, waits for its ack to fall, then enables the new one.
module clk_sel_ctrl #(
   parameter int N_CLK       = 2,
   parameter int SEL_W       = 1,
   parameter int DEFAULT_SEL = 0,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic [SEL_W-1:0] req_sel,
   output logic             req_ready,
   input  logic [N_CLK-1:0] gate_ack,
   output logic [N_CLK-1:0] gate_en,
   output logic [SEL_W-1:0] cur_sel,
   output logic             busy,
   output logic             switch_done,
   output logic             sel_err,
   output logic             timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [SEL_W-1:0] DEF_SEL  = SEL_W'(DEFAULT_SEL);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [SEL_W:0]   N_CLK_V  = (SEL_W + 1)'(N_CLK);

   typedef enum logic [1:0] {
      IDLE,
      OFF_WAIT,
      ON_WAIT
   } state_t;

   function automatic logic [N_CLK-1:0] onehot(input logic [SEL_W-1:0] s);
      onehot = N_CLK'(1) << s;
   endfunction

   logic [SYNC_STAGES-1:0][N_CLK-1:0] sync_q;
   logic [N_CLK-1:0] ack_s;

   state_t           state_q, state_d;
   logic [SEL_W-1:0] target_q, target_d;
   logic [SEL_W-1:0] cur_q, cur_d;
   logic [N_CLK-1:0] en_q, en_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             serr_q, serr_d;
   logic             tmo_q, tmo_d;
   logic             ready_q, ready_d;
   logic             accept;
   logic             req_bad;

   // gate_ack is asynchronous to clk; only the last stage is ever used
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], gate_ack};
      end
   end

   assign ack_s   = sync_q[SYNC_STAGES-1];
   assign accept  = req_valid & ready_q;
   assign req_bad = {1'b0, req_sel} >= N_CLK_V;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ON_WAIT;
         target_q <= DEF_SEL;
         cur_q    <= DEF_SEL;
         en_q     <= onehot(DEF_SEL);
         cnt_q    <= '0;
         done_q   <= 1'b0;
         serr_q   <= 1'b0;
         tmo_q    <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         cur_q    <= cur_d;
         en_q     <= en_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         serr_q   <= serr_d;
         tmo_q    <= tmo_d;
         ready_q  <= ready_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      cur_d    = cur_q;
      en_d     = en_q;
      cnt_d    = cnt_q + 1'b1;
      done_d   = 1'b0;
      serr_d   = 1'b0;
      tmo_d    = tmo_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept) begin
               tmo_d = 1'b0;
               if (req_bad) begin
                  serr_d = 1'b1;
               end else if (req_sel == cur_q) begin
                  done_d = 1'b1;
               end else begin
                  target_d = req_sel;
                  en_d     = '0;
                  state_d  = OFF_WAIT;
               end
            end
         end
         OFF_WAIT: begin
            if (!ack_s[cur_q]) begin
               en_d    = onehot(target_q);
               cur_d   = target_q;
               cnt_d   = '0;
               state_d = ON_WAIT;
            end else if (cnt_q == CNT_LAST) begin
               // old source may still run: restore it, never enable the new one
               tmo_d    = 1'b1;
               en_d     = onehot(cur_q);
               target_d = cur_q;
               cnt_d    = '0;
               state_d  = ON_WAIT;
            end
         end
         ON_WAIT: begin
            if (ack_s[target_q]) begin
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               tmo_d   = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      ready_d = (state_d == IDLE);
   end

   assign req_ready   = ready_q;
   assign busy        = ~ready_q;
   assign gate_en     = en_q;
   assign cur_sel     = cur_q;
   assign switch_done = done_q;
   assign sel_err     = serr_q;
   assign timeout_err = tmo_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// tb_clk_sel_ctrl: loopback gates with per-channel stuck overrides,
// random requests checked against a channel-level timing model.
module tb_clk_sel_ctrl;

   localparam int N  = 3;
   localparam int SW = 2;
   localparam int TO = 8;
   localparam int SS = 2;
   localparam int LAT = SS + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic [SW-1:0] req_sel = '0;
   logic          req_ready;
   logic [N-1:0]  gate_ack;
   logic [N-1:0]  gate_en;
   logic [SW-1:0] cur_sel;
   logic          busy;
   logic          switch_done;
   logic          sel_err;
   logic          timeout_err;
   logic [N-1:0]  force_hi = '0;
   logic [N-1:0]  force_lo = '0;

   int tests = 0;
   int fails = 0;
   int model_cur = 0;

   always #5 clk = ~clk;

   assign gate_ack = force_hi | (gate_en & ~force_lo);

   clk_sel_ctrl #(
      .N_CLK(N), .SEL_W(SW), .DEFAULT_SEL(0),
      .SYNC_STAGES(SS), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
      .gate_ack(gate_ack), .gate_en(gate_en), .cur_sel(cur_sel),
      .busy(busy), .switch_done(switch_done),
      .sel_err(sel_err), .timeout_err(timeout_err)
   );

   function automatic logic [N-1:0] oh(input int s);
      logic [N-1:0] v;
      v = '0;
      v[s] = 1'b1;
      return v;
   endfunction

   // Presents a request at a negedge; returns at the negedge after acceptance
   task automatic send(input int s);
      int n;
      n = 0;
      req_valid = 1'b1;
      req_sel = SW'(s);
      while (req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (req_ready !== 1'b1) begin
         fails++;
         $display("FAIL send_ready: req_ready=%b exp 1", req_ready);
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic test_reset(input string tag);
      @(negedge clk);
      rst = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      tests++;
      if ({gate_en, cur_sel, busy, req_ready, switch_done, sel_err, timeout_err}
          !== {oh(0), 2'd0, 5'b10000}) begin
         fails++;
         $display("FAIL %s_state: en=%b sel=%0d busy=%b rdy=%b done=%b serr=%b tmo=%b exp en=001 sel=0 busy=1 rest 0",
                  tag, gate_en, cur_sel, busy, req_ready, switch_done, sel_err, timeout_err);
      end
      rst = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         tests++;
         if ({switch_done, req_ready, gate_en} !== {(k == LAT), (k == LAT), oh(0)}) begin
            fails++;
            $display("FAIL %s_release k=%0d: done=%b rdy=%b en=%b exp done=%b rdy=%b en=001",
                     tag, k, switch_done, req_ready, gate_en, k == LAT, k == LAT);
         end
      end
      model_cur = 0;
   endtask

   task automatic test_switch(input int b);
      logic [N-1:0] e;
      send(b);
      for (int k = 0; k <= 2 * LAT; k++) begin
         if (k > 0) @(negedge clk);
         e = (k < LAT) ? '0 : oh(b);
         tests++;
         if (gate_en !== e) begin
            fails++;
            $display("FAIL sw_en k=%0d: got %b exp %b", k, gate_en, e);
         end
         tests++;
         if ({switch_done, req_ready, busy} !== {(k == 2 * LAT), (k == 2 * LAT), (k != 2 * LAT)}) begin
            fails++;
            $display("FAIL sw_hs k=%0d: done=%b rdy=%b busy=%b", k, switch_done, req_ready, busy);
         end
      end
      tests++;
      if ({cur_sel, timeout_err} !== {SW'(b), 1'b0}) begin
         fails++;
         $display("FAIL sw_end: cur_sel=%0d tmo=%b exp %0d 0", cur_sel, timeout_err, b);
      end
      model_cur = b;
   endtask

   task automatic test_same(input int s);
      send(s);
      tests++;
      if ({switch_done, req_ready, sel_err, timeout_err, gate_en} !== {4'b1100, oh(s)}) begin
         fails++;
         $display("FAIL same: done=%b rdy=%b serr=%b tmo=%b en=%b exp 1 1 0 0 %b",
                  switch_done, req_ready, sel_err, timeout_err, gate_en, oh(s));
      end
      @(negedge clk);
      tests++;
      if (switch_done !== 1'b0) begin
         fails++;
         $display("FAIL same_pulse: done=%b exp 0", switch_done);
      end
   endtask

   task automatic test_sel_err();
      send(3);
      tests++;
      if ({sel_err, switch_done, req_ready, gate_en, cur_sel} !== {3'b101, oh(model_cur), SW'(model_cur)}) begin
         fails++;
         $display("FAIL sel_err: serr=%b done=%b rdy=%b en=%b sel=%0d exp 1 0 1 %b %0d",
                  sel_err, switch_done, req_ready, gate_en, cur_sel, oh(model_cur), model_cur);
      end
      @(negedge clk);
      tests++;
      if (sel_err !== 1'b0) begin
         fails++;
         $display("FAIL sel_err_pulse: serr=%b exp 0", sel_err);
      end
   endtask

   task automatic test_off_timeout();
      logic [N-1:0] e;
      force_hi[0] = 1'b1;
      send(1);
      for (int k = 0; k <= TO + 1; k++) begin
         if (k > 0) @(negedge clk);
         e = (k < TO) ? '0 : oh(0);
         tests++;
         if ({gate_en, timeout_err, switch_done, req_ready} !== {e, (k >= TO), (k == TO + 1), (k == TO + 1)}) begin
            fails++;
            $display("FAIL off_tmo k=%0d: en=%b tmo=%b done=%b rdy=%b exp en=%b tmo=%b done/rdy=%b",
                     k, gate_en, timeout_err, switch_done, req_ready, e, k >= TO, k == TO + 1);
         end
      end
      tests++;
      if (cur_sel !== SW'(0)) begin
         fails++;
         $display("FAIL off_tmo_sel: cur_sel=%0d exp 0", cur_sel);
      end
      force_hi = '0;
      model_cur = 0;
   endtask

   task automatic test_on_timeout();
      logic [N-1:0] e;
      force_lo[1] = 1'b1;
      send(1);
      for (int k = 0; k <= LAT + TO; k++) begin
         if (k > 0) @(negedge clk);
         e = (k < LAT) ? '0 : oh(1);
         tests++;
         if ({gate_en, timeout_err, req_ready, switch_done} !== {e, (k == LAT + TO), (k == LAT + TO), 1'b0}) begin
            fails++;
            $display("FAIL on_tmo k=%0d: en=%b tmo=%b rdy=%b done=%b exp en=%b tmo/rdy=%b done=0",
                     k, gate_en, timeout_err, req_ready, switch_done, e, k == LAT + TO);
         end
      end
      tests++;
      if (cur_sel !== SW'(1)) begin
         fails++;
         $display("FAIL on_tmo_sel: cur_sel=%0d exp 1", cur_sel);
      end
      force_lo = '0;
      model_cur = 1;
   endtask

   task automatic test_rst_mid(input int j, input string tag);
      send(1);
      repeat (j) @(negedge clk);
      test_reset(tag);
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] e;
      req_valid = 1'b1;
      req_sel = SW'(1);
      tests++;
      if (req_ready !== 1'b1) begin
         fails++;
         $display("FAIL b2b_ready0: req_ready=%b exp 1", req_ready);
      end
      @(negedge clk);
      req_sel = SW'(2);
      for (int k = 1; k <= 2 * LAT; k++) begin
         @(negedge clk);
         e = (k < LAT) ? '0 : oh(1);
         tests++;
         if ({req_ready, switch_done, gate_en} !== {(k == 2 * LAT), (k == 2 * LAT), e}) begin
            fails++;
            $display("FAIL b2b_first k=%0d: rdy=%b done=%b en=%b exp rdy/done=%b en=%b",
                     k, req_ready, switch_done, gate_en, k == 2 * LAT, e);
         end
      end
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 0; k <= 2 * LAT; k++) begin
         if (k > 0) @(negedge clk);
         e = (k < LAT) ? '0 : oh(2);
         tests++;
         if ({gate_en, switch_done} !== {e, (k == 2 * LAT)}) begin
            fails++;
            $display("FAIL b2b_second k=%0d: en=%b done=%b exp en=%b done=%b",
                     k, gate_en, switch_done, e, k == 2 * LAT);
         end
      end
      tests++;
      if (cur_sel !== SW'(2)) begin
         fails++;
         $display("FAIL b2b_sel: cur_sel=%0d exp 2", cur_sel);
      end
      model_cur = 2;
   endtask

   task automatic test_random(input int n);
      int s;
      for (int i = 0; i < n; i++) begin
         s = $urandom_range(0, 3);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         if (s >= N) test_sel_err();
         else if (s == model_cur) test_same(s);
         else test_switch(s);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset("reset");
      test_switch(1);
      test_same(1);
      test_sel_err();
      test_switch(0);
      test_off_timeout();
      test_same(0);
      test_on_timeout();
      test_reset("reset_idle");
      test_rst_mid(0, "rst_off");
      test_rst_mid(3, "rst_on");
      test_back_to_back();
      test_random(40);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
